// File: rtl/mdp_pkg.sv
// Shared definitions for the MDP3.0 book entry parser and the order book stage.
// Holds the SBE entry field layout (byte offsets and widths within one
// NoMDEntries group entry), the parser FSM state type, the packed book entry
// record, and the MDUpdateAction / MDEntryType code points.
package mdp_pkg;

    // Smallest legal entry blockLength: covers everything through MDEntryType.
    localparam int unsigned BLK_LEN_MIN = 27;

    // Byte offsets of each field within a group entry.
    localparam int unsigned PX_OFF    = 0;
    localparam int unsigned SIZE_OFF  = 8;
    localparam int unsigned SECID_OFF = 12;
    localparam int unsigned SEQ_OFF   = 16;
    localparam int unsigned NORD_OFF  = 20;
    localparam int unsigned LVL_OFF   = 24;
    localparam int unsigned ACT_OFF   = 25;
    localparam int unsigned TYPE_OFF  = 26;

    // Field widths in bits.
    localparam int unsigned PX_W    = 64;
    localparam int unsigned SIZE_W  = 32;
    localparam int unsigned SECID_W = 32;
    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned NORD_W  = 32;
    localparam int unsigned LVL_W   = 8;
    localparam int unsigned ACT_W   = 8;
    localparam int unsigned TYPE_W  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StEntry,
        StEmit,
        StDrain
    } state_e;

    // price is a signed mantissa with an implied exponent of -9.
    typedef struct packed {
        logic [ACT_W-1:0]   update_action;
        logic [TYPE_W-1:0]  entry_type;
        logic [NORD_W-1:0]  num_orders;
        logic [PX_W-1:0]    price;
        logic [SIZE_W-1:0]  size;
        logic [SECID_W-1:0] security_id;
        logic [SEQ_W-1:0]   rpt_seq;
        logic [LVL_W-1:0]   price_level;
    } book_entry_t;

    typedef enum logic [7:0] {
        ActNew    = 8'd0,
        ActChange = 8'd1,
        ActDelete = 8'd2
    } md_action_e;

    typedef enum logic [7:0] {
        TypeBid   = 8'h30,
        TypeOffer = 8'h31
    } md_entry_type_e;

endpackage

// File: rtl/mdp_book_entry_parser_if.sv
// Byte-stream input and decoded-entry output of the book entry parser.
//   s_*  : message body bytes (s_data, s_valid, s_last in; s_ready back)
//   e_*  : one decoded group entry per valid/ready handshake
// modport slave  : the parser (consumes bytes, produces entries)
// modport master : the surrounding environment (feeds bytes, sinks entries)
interface mdp_book_entry_parser_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        e_valid;
    logic        e_ready;
    logic [7:0]  e_update_action;
    logic [7:0]  e_entry_type;
    logic [31:0] e_num_orders;
    logic [63:0] e_price;
    logic [31:0] e_size;
    logic [31:0] e_security_id;
    logic [31:0] e_rpt_seq;
    logic [7:0]  e_price_level;
    logic [7:0]  e_num_entries;
    logic [7:0]  e_index;
    logic        e_last;

    modport slave (
        input  s_data, s_valid, s_last, e_ready,
        output s_ready, e_valid, e_update_action, e_entry_type, e_num_orders, e_price,
               e_size, e_security_id, e_rpt_seq, e_price_level, e_num_entries, e_index,
               e_last
    );

    modport master (
        output s_data, s_valid, s_last, e_ready,
        input  s_ready, e_valid, e_update_action, e_entry_type, e_num_orders, e_price,
               e_size, e_security_id, e_rpt_seq, e_price_level, e_num_entries, e_index,
               e_last
    );
endinterface

// File: rtl/mdp_le_field.sv
// Little-endian byte-lane capture register for one SBE field.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : zero the field
//   en_i     : a byte is being accepted at entry offset off_i
//   off_i    : byte offset within the current entry
//   data_i   : the byte
//   q_o      : captured field value
// A byte at offset BaseOff+k lands in lane k; other offsets are ignored.
module mdp_le_field #(
    parameter int unsigned Width   = 32,
    parameter int unsigned BaseOff = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [15:0]      off_i,
    input  logic [7:0]       data_i,
    output logic [Width-1:0] q_o
);
    localparam int unsigned Lanes = Width / 8;

    logic [Width-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            for (int unsigned i = 0; i < Lanes; i++) begin
                if (off_i == 16'(BaseOff + i)) begin
                    q_d[i*8 +: 8] = data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/mdp_book_entry_parser.sv
// MDP3.0 MDIncrementalRefreshBook entry parser. Consumes the message body from
// the NoMDEntries groupSize header (blockLength u16, numInGroup u8) onward and
// presents each group entry as a parallel record on a valid/ready handshake.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : s_* byte stream in, e_* decoded entry out
//   err          : one-cycle pulse on a malformed or truncated message
// Optional build macro MDP_PARSER_STATS_EN adds stat_entries (handshaken
// entries) and stat_errors (err pulses), both free-running wrapping counters.
module mdp_book_entry_parser
    import mdp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    mdp_book_entry_parser_if.slave   bus,
    output logic                     err
`ifdef MDP_PARSER_STATS_EN
    ,
    output logic [31:0]              stat_entries,
    output logic [15:0]              stat_errors
`endif
);
    state_e      state_q, state_d;
    logic        s_ready_q, s_ready_d;
    logic        hdr_cnt_q, hdr_cnt_d;
    logic [15:0] blk_len_q, blk_len_d;
    logic [7:0]  num_q, num_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] off_q, off_d;
    logic        seen_last_q, seen_last_d;  // s_last arrived on the entry's final byte
    logic        err_q, err_d;

    logic        accept, ent_last, emit_hs, fld_en, fld_clr;
    book_entry_t entry;

    assign accept   = bus.s_valid && s_ready_q;
    assign ent_last = (idx_q + 8'd1) == num_q;
    assign emit_hs  = (state_q == StEmit) && bus.e_ready;
    assign fld_en   = accept && (state_q == StEntry);
    assign fld_clr  = (state_d == StEntry) && (state_q != StEntry);

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        blk_len_d   = blk_len_q;
        num_d       = num_q;
        idx_d       = idx_q;
        off_d       = off_q;
        seen_last_d = seen_last_q;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    blk_len_d = {8'h00, bus.s_data};
                    hdr_cnt_d = 1'b0;
                    if (bus.s_last) err_d = 1'b1;
                    else            state_d = StHdr;
                end
            end
            StHdr: begin
                if (accept && !hdr_cnt_q) begin
                    blk_len_d[15:8] = bus.s_data;
                    hdr_cnt_d       = 1'b1;
                    if (bus.s_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    num_d       = bus.s_data;
                    idx_d       = 8'd0;
                    off_d       = 16'd0;
                    seen_last_d = 1'b0;
                    if (bus.s_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (blk_len_q < 16'(BLK_LEN_MIN)) begin
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end else if (bus.s_data == 8'd0) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StEntry;
                    end
                end
            end
            StEntry: begin
                if (accept) begin
                    if (off_q == blk_len_q - 16'd1) begin
                        state_d     = StEmit;
                        seen_last_d = bus.s_last;
                        // Message ended while more entries were promised.
                        if (bus.s_last && !ent_last) err_d = 1'b1;
                    end else if (bus.s_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        off_d = off_q + 16'd1;
                    end
                end
            end
            StEmit: begin
                if (bus.e_ready) begin
                    if (seen_last_q) begin
                        state_d = StIdle;
                    end else if (ent_last) begin
                        state_d = StDrain;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        off_d   = 16'd0;
                        state_d = StEntry;
                    end
                end
            end
            StDrain: begin
                if (accept && bus.s_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Registered from next state so s_ready never depends on e_ready combinationally.
        s_ready_d = (state_d != StEmit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            s_ready_q   <= 1'b0;
            hdr_cnt_q   <= 1'b0;
            blk_len_q   <= 16'd0;
            num_q       <= 8'd0;
            idx_q       <= 8'd0;
            off_q       <= 16'd0;
            seen_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            hdr_cnt_q   <= hdr_cnt_d;
            blk_len_q   <= blk_len_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            seen_last_q <= seen_last_d;
            err_q       <= err_d;
        end
    end

    mdp_le_field #(.Width(PX_W), .BaseOff(PX_OFF)) u_px (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data), .q_o(entry.price));
    mdp_le_field #(.Width(SIZE_W), .BaseOff(SIZE_OFF)) u_size (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data), .q_o(entry.size));
    mdp_le_field #(.Width(SECID_W), .BaseOff(SECID_OFF)) u_secid (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data),
        .q_o(entry.security_id));
    mdp_le_field #(.Width(SEQ_W), .BaseOff(SEQ_OFF)) u_seq (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data), .q_o(entry.rpt_seq));
    mdp_le_field #(.Width(NORD_W), .BaseOff(NORD_OFF)) u_nord (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data),
        .q_o(entry.num_orders));
    mdp_le_field #(.Width(LVL_W), .BaseOff(LVL_OFF)) u_lvl (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data),
        .q_o(entry.price_level));
    mdp_le_field #(.Width(ACT_W), .BaseOff(ACT_OFF)) u_act (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data),
        .q_o(entry.update_action));
    mdp_le_field #(.Width(TYPE_W), .BaseOff(TYPE_OFF)) u_type (.clk(clk), .rst(rst),
        .clr_i(fld_clr), .en_i(fld_en), .off_i(off_q), .data_i(bus.s_data),
        .q_o(entry.entry_type));

    assign bus.s_ready         = s_ready_q;
    assign bus.e_valid         = (state_q == StEmit);
    assign bus.e_update_action = entry.update_action;
    assign bus.e_entry_type    = entry.entry_type;
    assign bus.e_num_orders    = entry.num_orders;
    assign bus.e_price         = entry.price;
    assign bus.e_size          = entry.size;
    assign bus.e_security_id   = entry.security_id;
    assign bus.e_rpt_seq       = entry.rpt_seq;
    assign bus.e_price_level   = entry.price_level;
    assign bus.e_num_entries   = num_q;
    assign bus.e_index         = idx_q;
    assign bus.e_last          = ent_last;
    assign err                 = err_q;

`ifdef MDP_PARSER_STATS_EN
    logic [31:0] stat_entries_q, stat_entries_d;
    logic [15:0] stat_errors_q, stat_errors_d;

    always_comb begin
        stat_entries_d = stat_entries_q + {31'd0, emit_hs};
        stat_errors_d  = stat_errors_q + {15'd0, err_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_entries_q <= 32'd0;
            stat_errors_q  <= 16'd0;
        end else begin
            stat_entries_q <= stat_entries_d;
            stat_errors_q  <= stat_errors_d;
        end
    end

    assign stat_entries = stat_entries_q;
    assign stat_errors  = stat_errors_q;
`endif
endmodule

// File: tb/tb_mdp_book_entry_parser.sv
module tb_mdp_book_entry_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
`ifdef MDP_PARSER_STATS_EN
    logic [31:0] stat_entries;
    logic [15:0] stat_errors;
`endif

    mdp_book_entry_parser_if bus ();

    mdp_book_entry_parser dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err(err)
`ifdef MDP_PARSER_STATS_EN
        ,
        .stat_entries(stat_entries),
        .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  act;
        logic [7:0]  typ;
        logic [31:0] nord;
        logic [63:0] px;
        logic [31:0] size;
        logic [31:0] sec;
        logic [31:0] seq;
        logic [7:0]  lvl;
        logic [7:0]  num;
        logic [7:0]  idx;
        logic        last;
    } rec_t;

    byte unsigned msg[$];
    int           acc_cyc[$];   // cycle number at which each byte was taken
    rec_t         got_q[$];
    rec_t         exp_q[$];
    int           got_err, exp_err;
    int           first_valid_cyc, first_err_cyc;
    int           n_assert = 0;
    int           n_fail = 0;
    int           stall0 = 0;
    bit           rand_stall = 0;
    bit           rand_gaps = 0;
    bit           drv_done;
    bit           stable_ok, sready_ok;

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- message construction ----------------
    task automatic push_le(logic [63:0] v, int nb);
        for (int b = 0; b < nb; b++) msg.push_back(v[8*b +: 8]);
    endtask

    task automatic hdr(int blk, int num);
        msg.delete();
        push_le(64'(blk), 2);
        msg.push_back(8'(num));
    endtask

    task automatic entry(int blk, logic [63:0] px, logic [31:0] size, logic [31:0] sec,
                         logic [31:0] seq, logic [31:0] nord, logic [7:0] lvl,
                         logic [7:0] act, logic [7:0] typ);
        push_le(px, 8);
        push_le(64'(size), 4);
        push_le(64'(sec), 4);
        push_le(64'(seq), 4);
        push_le(64'(nord), 4);
        msg.push_back(lvl);
        msg.push_back(act);
        msg.push_back(typ);
        for (int p = 27; p < blk; p++) msg.push_back(8'($urandom));
    endtask

    task automatic rand_entry(int blk);
        entry(blk, {$urandom, $urandom}, $urandom, $urandom, $urandom, $urandom,
              8'($urandom), 8'($urandom_range(0, 2)), 8'($urandom_range(8'h30, 8'h31)));
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] le(int pos, int nb);
        logic [63:0] v = 64'd0;
        for (int b = 0; b < nb; b++) v = v | (64'(msg[pos+b]) << (8 * b));
        return v;
    endfunction

    // Walk the whole message as a byte array: which complete entries exist, and
    // does the message end early or carry an illegal blockLength.
    task automatic model();
        int n, blk, num, start;
        rec_t r;
        n = msg.size();
        exp_q.delete();
        exp_err = 0;
        if (n < 4) begin
            exp_err = 1;
            return;
        end
        blk = int'(msg[0]) + 256 * int'(msg[1]);
        num = int'(msg[2]);
        if (blk < 27) begin
            exp_err = 1;
            return;
        end
        for (int k = 0; k < num; k++) begin
            start = 3 + k * blk;
            if (start + blk > n) begin
                exp_err = 1;
                return;
            end
            r.px   = le(start, 8);
            r.size = 32'(le(start + 8, 4));
            r.sec  = 32'(le(start + 12, 4));
            r.seq  = 32'(le(start + 16, 4));
            r.nord = 32'(le(start + 20, 4));
            r.lvl  = msg[start+24];
            r.act  = msg[start+25];
            r.typ  = msg[start+26];
            r.num  = 8'(num);
            r.idx  = 8'(k);
            r.last = (k == num - 1);
            exp_q.push_back(r);
            if (start + blk == n) begin
                if (k != num - 1) exp_err = 1;
                return;
            end
        end
    endtask

    // ---------------- driver / sink ----------------
    function automatic rec_t sample();
        rec_t r;
        r.act  = bus.e_update_action;
        r.typ  = bus.e_entry_type;
        r.nord = bus.e_num_orders;
        r.px   = bus.e_price;
        r.size = bus.e_size;
        r.sec  = bus.e_security_id;
        r.seq  = bus.e_rpt_seq;
        r.lvl  = bus.e_price_level;
        r.num  = bus.e_num_entries;
        r.idx  = bus.e_index;
        r.last = bus.e_last;
        return r;
    endfunction

    task automatic send(bit with_last);
        int i = 0;
        int guard = 0;
        acc_cyc.delete();
        while (i < msg.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (rand_gaps && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                bus.s_data  = 8'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = msg[i];
                bus.s_last  = with_last && (i == msg.size() - 1);
                // s_ready is registered, so its value now is what the next edge sees.
                if (bus.s_ready) begin
                    acc_cyc.push_back(cyc + 1);
                    i++;
                end
            end
        end
        check("driver byte budget", 32'(i), 32'(msg.size()));
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic sink();
        int   idle = 0;
        int   guard = 0;
        int   stall_left = 0;
        bit   in_beat = 0;
        rec_t first;
        while (!(drv_done && idle >= 6) && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (err) begin
                got_err++;
                if (first_err_cyc < 0) first_err_cyc = cyc;
            end
            if (bus.e_valid) begin
                idle = 0;
                if (bus.s_ready !== 1'b0) sready_ok = 0;
                if (!in_beat) begin
                    in_beat = 1;
                    first   = sample();
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    stall_left = rand_stall ? $urandom_range(0, 3)
                                            : (got_q.size() == 0 ? stall0 : 0);
                end else if (sample() !== first) begin
                    stable_ok = 0;
                end
                if (stall_left > 0) begin
                    bus.e_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.e_ready = 1'b1;
                    got_q.push_back(first);
                    in_beat = 0;
                end
            end else begin
                idle++;
                bus.e_ready = 1'($urandom_range(0, 1));
            end
        end
        check("sink cycle budget", 32'(guard < 5000), 32'd1);
        bus.e_ready = 1'b1;
    endtask

    task automatic run_msg(string tag);
        model();
        got_q.delete();
        got_err         = 0;
        drv_done        = 0;
        stable_ok       = 1;
        sready_ok       = 1;
        first_valid_cyc = -1;
        first_err_cyc   = -1;
        fork
            begin
                send(1'b1);
                drv_done = 1;
            end
            sink();
        join
        check({tag, " entry count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s entry%0d", tag, k), got_q[k], exp_q[k]);
        check({tag, " err pulses"}, 32'(got_err), 32'(exp_err));
        check({tag, " fields stable while stalled"}, 32'(stable_ok), 32'd1);
        check({tag, " s_ready low while e_valid"}, 32'(sready_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h00;
        bus.e_ready = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst s_ready", 32'(bus.s_ready), 32'd0);
        check("rst e_valid", 32'(bus.e_valid), 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst s_ready", 32'(bus.s_ready), 32'd1);
        check("post-rst e_valid", 32'(bus.e_valid), 32'd0);
        check("post-rst e_price", bus.e_price, 64'd0);
        check("post-rst e_index", 32'(bus.e_index), 32'd0);
        check("post-rst e_num_entries", 32'(bus.e_num_entries), 32'd0);

        // Two 32-byte entries, two trailing padding bytes.
        hdr(32, 2);
        entry(32, 64'h0000_0001_2A05_F200, 32'd10, 32'd777, 32'd100, 32'd3, 8'd1, 8'd0, 8'h30);
        entry(32, 64'h0000_0001_2A05_F200, 32'd25, 32'd777, 32'd101, 32'd3, 8'd2, 8'd0, 8'h30);
        push_le(64'hBEEF, 2);
        run_msg("basic");
        if (got_q.size() > 1) begin
            check("basic px", got_q[0].px, 64'h0000_0001_2A05_F200);
            check("basic last on 2nd", 32'({got_q[0].last, got_q[1].last}), 32'b01);
            check("basic idx 2nd", 32'(got_q[1].idx), 32'd1);
        end
        if (acc_cyc.size() > 34)
            check("basic e_valid latency", 32'(first_valid_cyc), 32'(acc_cyc[34]));

        // Same message, 5-cycle stall on entry 0.
        stall0 = 5;
        run_msg("stall");
        stall0 = 0;

        // Empty group followed by trailing bytes.
        hdr(27, 0);
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        run_msg("empty group");

        // blockLength below minimum.
        hdr(20, 3);
        for (int i = 0; i < 30; i++) msg.push_back(8'($urandom));
        run_msg("short blk");
        if (acc_cyc.size() > 2)
            check("short blk err timing", 32'(first_err_cyc), 32'(acc_cyc[2]));

        // s_last at offset 14 of entry 1 of 3.
        hdr(27, 3);
        rand_entry(27);
        rand_entry(27);
        while (msg.size() > 3 + 27 + 15) void'(msg.pop_back());
        run_msg("trunc mid entry");

        // Message ends exactly after a non-final entry.
        hdr(30, 2);
        rand_entry(30);
        run_msg("early end");

        // Reset mid-entry, then a fresh single-entry message.
        hdr(28, 2);
        rand_entry(28);
        while (msg.size() > 13) void'(msg.pop_back());
        send(1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid rst s_ready", 32'(bus.s_ready), 32'd0);
        check("mid rst e_valid", 32'(bus.e_valid), 32'd0);
        check("mid rst err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        hdr(27, 1);
        rand_entry(27);
        run_msg("after rst");

        // Randomized messages with gaps, stalls, bad lengths and truncation.
        rand_gaps  = 1;
        rand_stall = 1;
        for (int t = 0; t < 14; t++) begin
            int blk, num;
            blk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 26) : $urandom_range(27, 40);
            num = $urandom_range(1, 4);
            hdr(blk, num);
            for (int k = 0; k < num; k++) rand_entry(blk);
            repeat ($urandom_range(0, 5)) msg.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                int keep;
                keep = $urandom_range(1, msg.size());
                while (msg.size() > keep) void'(msg.pop_back());
            end
            run_msg($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
